instr_fetch_queue: RTL and testbench

//  Fetch stage directly upstream of the instruction decoder. Generates sequential word

---
 rtl/instr_fetch_queue_if.sv | 56 +++++
 rtl/instr_fetch_queue.sv | 214 +++++++++++++++++++++
 tb/tb_instr_fetch_queue.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_queue_if.sv
// Bundle of fetch-stage signals: redirect input, instruction memory request/response,
// decode handshake and performance counters. The fetch queue uses the master view;
// the surrounding environment (memory, decoder, branch unit) uses the slave view.
interface instr_fetch_queue_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_fault;
  logic [31:0] perf_empty_cyc;
  logic [15:0] perf_flushes;

  modport master (
    input  redirect_valid,
    input  redirect_pc,
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  imem_rsp_err,
    output dec_valid,
    input  dec_ready,
    output dec_instr,
    output dec_pc,
    output dec_fault,
    output perf_empty_cyc,
    output perf_flushes
  );

  modport slave (
    output redirect_valid,
    output redirect_pc,
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    output imem_rsp_err,
    input  dec_valid,
    output dec_ready,
    input  dec_instr,
    input  dec_pc,
    input  dec_fault,
    input  perf_empty_cyc,
    input  perf_flushes
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches under a credit limit of DEPTH
// (queued + in-flight), buffers in-order responses with their PC and presents the head
// to decode from registers. A redirect flushes the queue and kills stale responses.
// Optional macro FETCH_PERF_EN enables the saturating performance counters; without it
// the counter outputs are tied to zero.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0100
) (
  input logic                clk,
  input logic                reset,
  instr_fetch_queue_if.master bus
);

  localparam int unsigned   CW      = $clog2(DEPTH + 1);
  localparam int unsigned   AW      = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Architectural state
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_kill;
  logic          r_halted;
  logic          r_req_hold;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;

  // Queue storage
  logic [31:0] r_q_instr [DEPTH];
  logic [31:0] r_q_pc    [DEPTH];
  logic        r_q_fault [DEPTH];

  // Registered head presented to decode
  logic [31:0] r_dec_instr;
  logic [31:0] r_dec_pc;
  logic        r_dec_fault;

  // Next-state and control wires
  logic          w_req_valid;
  logic          w_req_fire;
  logic          w_credit_ok;
  logic [CW:0]   w_used;
  logic          w_push;
  logic          w_pop;
  logic          w_rsp_drop;
  logic          w_bypass;
  logic          w_head_load;
  logic [31:0]   w_redirect_pc;
  logic [31:0]   w_fetch_pc_d;
  logic [31:0]   w_rsp_pc_d;
  logic [CW-1:0] w_count_d;
  logic [CW-1:0] w_inflight_d;
  logic [CW-1:0] w_kill_d;
  logic          w_halted_d;
  logic          w_req_hold_d;
  logic [AW-1:0] w_wr_ptr_d;
  logic [AW-1:0] w_rd_ptr_d;
  logic          w_unused_redirect_lsb;

  assign w_unused_redirect_lsb = ^bus.redirect_pc[1:0];
  assign w_redirect_pc         = {bus.redirect_pc[31:2], 2'b00};

  // Handshake decode: credit check, request issue, push/pop/drop qualification
  always_comb begin
    w_used      = {1'b0, r_count} + {1'b0, r_inflight};
    w_credit_ok = w_used < {1'b0, DEPTH_C};
    // An offered request stays up until accepted; only a redirect withdraws it.
    w_req_valid = !reset && !bus.redirect_valid &&
                  (r_req_hold || (!r_halted && w_credit_ok));
    w_req_fire  = w_req_valid && bus.imem_req_ready;
    w_rsp_drop  = bus.imem_rsp_valid && (r_kill != '0);
    w_push      = bus.imem_rsp_valid && (r_kill == '0) && !bus.redirect_valid;
    w_pop       = (r_count != '0) && bus.dec_ready && !bus.redirect_valid;
  end

  // Next-state computation; redirect overrides every other update
  always_comb begin
    w_fetch_pc_d = r_fetch_pc;
    w_rsp_pc_d   = r_rsp_pc;
    w_count_d    = r_count;
    w_inflight_d = r_inflight + CW'(w_req_fire) - CW'(bus.imem_rsp_valid);
    w_kill_d     = r_kill;
    w_halted_d   = r_halted;
    w_req_hold_d = w_req_valid && !bus.imem_req_ready;
    w_wr_ptr_d   = r_wr_ptr;
    w_rd_ptr_d   = r_rd_ptr;
    if (bus.redirect_valid) begin
      w_fetch_pc_d = w_redirect_pc;
      w_rsp_pc_d   = w_redirect_pc;
      w_count_d    = '0;
      // Every request still owed a response belongs to the old stream.
      w_kill_d     = r_inflight - CW'(bus.imem_rsp_valid);
      w_halted_d   = 1'b0;
      w_wr_ptr_d   = '0;
      w_rd_ptr_d   = '0;
    end else begin
      if (w_req_fire) begin
        w_fetch_pc_d = r_fetch_pc + 32'd4;
      end
      if (w_rsp_drop) begin
        w_kill_d = r_kill - CW'(1);
      end
      if (w_push) begin
        w_rsp_pc_d = r_rsp_pc + 32'd4;
        w_wr_ptr_d = r_wr_ptr + AW'(1);
        if (bus.imem_rsp_err) begin
          w_halted_d = 1'b1;
        end
      end
      if (w_pop) begin
        w_rd_ptr_d = r_rd_ptr + AW'(1);
      end
      w_count_d = r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Head register source: a push into an (effectively) empty queue goes straight to decode
  always_comb begin
    w_bypass    = w_push && (r_count == CW'(w_pop));
    w_head_load = !bus.redirect_valid && (w_count_d != '0);
  end

  // Control and pointer state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_count    <= '0;
      r_inflight <= '0;
      r_kill     <= '0;
      r_halted   <= 1'b0;
      r_req_hold <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_fetch_pc <= w_fetch_pc_d;
      r_rsp_pc   <= w_rsp_pc_d;
      r_count    <= w_count_d;
      r_inflight <= w_inflight_d;
      r_kill     <= w_kill_d;
      r_halted   <= w_halted_d;
      r_req_hold <= w_req_hold_d;
      r_wr_ptr   <= w_wr_ptr_d;
      r_rd_ptr   <= w_rd_ptr_d;
    end
  end

  // Queue storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_instr[r_wr_ptr] <= bus.imem_rsp_data;
      r_q_pc[r_wr_ptr]    <= r_rsp_pc;
      r_q_fault[r_wr_ptr] <= bus.imem_rsp_err;
    end
  end

  // Decode head registers; hold their last value while the queue is empty
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dec_instr <= '0;
      r_dec_pc    <= '0;
      r_dec_fault <= 1'b0;
    end else if (w_head_load) begin
      if (w_bypass) begin
        r_dec_instr <= bus.imem_rsp_data;
        r_dec_pc    <= r_rsp_pc;
        r_dec_fault <= bus.imem_rsp_err;
      end else begin
        r_dec_instr <= r_q_instr[w_rd_ptr_d];
        r_dec_pc    <= r_q_pc[w_rd_ptr_d];
        r_dec_fault <= r_q_fault[w_rd_ptr_d];
      end
    end
  end

  // Output drive
  always_comb begin
    bus.imem_req_valid = w_req_valid;
    bus.imem_req_addr  = r_fetch_pc;
    bus.dec_valid      = r_count != '0;
    bus.dec_instr      = r_dec_instr;
    bus.dec_pc         = r_dec_pc;
    bus.dec_fault      = r_dec_fault;
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_empty_cyc;
  logic [15:0] r_perf_flushes;

  // Saturating counters: decode starved cycles and redirects
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_empty_cyc <= '0;
      r_perf_flushes   <= '0;
    end else begin
      if (bus.dec_ready && (r_count == '0) && (r_perf_empty_cyc != '1)) begin
        r_perf_empty_cyc <= r_perf_empty_cyc + 32'd1;
      end
      if (bus.redirect_valid && (r_perf_flushes != '1)) begin
        r_perf_flushes <= r_perf_flushes + 16'd1;
      end
    end
  end

  assign bus.perf_empty_cyc = r_perf_empty_cyc;
  assign bus.perf_flushes   = r_perf_flushes;
`else
  assign bus.perf_empty_cyc = '0;
  assign bus.perf_flushes   = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue. A memory/decoder environment drives the DUT;
// expectations come from a stream-level model: requests tagged with a redirect epoch,
// a queue of expected {pc, instr, fault} entries, and a sequential fetch PC per epoch.
module tb_instr_fetch_queue;

  logic clk = 1'b0;
  logic reset;
  logic reset2;
  always #5 clk = ~clk;

  instr_fetch_queue_if bus ();
  instr_fetch_queue_if bus2 ();

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0100)) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
    .clk  (clk),
    .reset(reset2),
    .bus  (bus2)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    int unsigned ep;
    int unsigned acc_cyc;
  } req_t;

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] exp_addr;
  } vec_t;

  ent_t        mq[$];      // expected decode queue
  req_t        mem_q[$];   // accepted requests awaiting a response
  int unsigned epoch = 0;
  logic [31:0] m_fetch_pc;
  logic        m_halted;
  logic        m_hold;
  logic [31:0] m_empty;
  logic [15:0] m_flush;

  int          k_rdy, k_rsp, k_dec;
  logic [31:0] err_pc = 32'h1;
  bit          rand_err = 0;

  logic [31:0] obs_first_fire, obs_first_pop, obs_fault_pc;
  int          obs_n_fire, obs_n_pop;
  bit          obs_fault_seen;

  function automatic logic [31:0] data_of(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'hA5C3_1E77;
  endfunction

  function automatic logic err_of(input logic [31:0] pc);
    return (pc == err_pc) || (rand_err && (pc[6:2] == 5'd9));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clr_obs();
    obs_first_fire = '0;
    obs_first_pop  = '0;
    obs_fault_pc   = '0;
    obs_n_fire     = 0;
    obs_n_pop      = 0;
    obs_fault_seen = 0;
  endtask

  function automatic bit pick(input int mode);
    if (mode == 1) return 1'b1;
    if (mode == 2) return 1'($urandom_range(0, 1));
    return 1'b0;
  endfunction

  task automatic idle_inputs();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.imem_rsp_err   = 1'b0;
    bus.dec_ready      = 1'b0;
  endtask

  // Holds reset over a clock edge, checks reset values, leaves reset asserted.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    check("rst_req_valid", bus.imem_req_valid, 0);
    check("rst_dec_valid", bus.dec_valid, 0);
    check("rst_dec_instr", bus.dec_instr, 0);
    check("rst_dec_pc", bus.dec_pc, 0);
    check("rst_dec_fault", bus.dec_fault, 0);
    check("rst_perf_empty", bus.perf_empty_cyc, 0);
    check("rst_perf_flush", bus.perf_flushes, 0);
    mq.delete();
    mem_q.delete();
    epoch++;
    m_fetch_pc = 32'h0000_0100;
    m_halted   = 1'b0;
    m_hold     = 1'b0;
    m_empty    = '0;
    m_flush    = '0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input bit redir, input logic [31:0] rpc);
    bit   rdy, drdy, give, exp_v, was_empty;
    req_t r;
    ent_t e;
    @(negedge clk);
    cyc++;
    reset              = 1'b0;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    rdy                = pick(k_rdy);
    drdy               = pick(k_dec);
    bus.imem_req_ready = rdy;
    bus.dec_ready      = drdy;
    give = (mem_q.size() > 0) && (mem_q[0].acc_cyc < cyc) &&
           ((k_rsp == 1) || ((k_rsp == 2) && ($urandom_range(0, 2) != 0)));
    bus.imem_rsp_valid = give;
    if (give) begin
      bus.imem_rsp_data = data_of(mem_q[0].addr);
      bus.imem_rsp_err  = err_of(mem_q[0].addr);
    end else begin
      bus.imem_rsp_data = $urandom;
      bus.imem_rsp_err  = 1'($urandom_range(0, 1));
    end
    #1;
    exp_v = !redir && (m_hold || (!m_halted && ((mq.size() + mem_q.size()) < 4)));
    check("req_valid", bus.imem_req_valid, exp_v);
    if (exp_v) check("req_addr", bus.imem_req_addr, m_fetch_pc);
    check("dec_valid", bus.dec_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("dec_pc", bus.dec_pc, mq[0].pc);
      check("dec_instr", bus.dec_instr, mq[0].instr);
      check("dec_fault", bus.dec_fault, mq[0].fault);
    end
`ifdef FETCH_PERF_EN
    check("perf_empty", bus.perf_empty_cyc, m_empty);
    check("perf_flush", bus.perf_flushes, m_flush);
`else
    check("perf_empty", bus.perf_empty_cyc, 0);
    check("perf_flush", bus.perf_flushes, 0);
`endif
    // observations of what the DUT actually did, for directed checks
    if (bus.imem_req_valid && rdy) begin
      if (obs_n_fire == 0) obs_first_fire = bus.imem_req_addr;
      obs_n_fire++;
    end
    if (bus.dec_valid && drdy && !redir) begin
      if (obs_n_pop == 0) obs_first_pop = bus.dec_pc;
      obs_n_pop++;
      if (bus.dec_fault) begin
        obs_fault_seen = 1;
        obs_fault_pc   = bus.dec_pc;
      end
    end
    // model update for the coming edge
    was_empty = (mq.size() == 0);
    if (drdy && was_empty && (m_empty != 32'hFFFF_FFFF)) m_empty++;
    if (redir && (m_flush != 16'hFFFF)) m_flush++;
    if (exp_v && rdy) begin
      mem_q.push_back('{addr: m_fetch_pc, ep: epoch, acc_cyc: cyc});
      m_fetch_pc += 32'd4;
    end
    m_hold = exp_v && !rdy;
    if (!was_empty && drdy && !redir) void'(mq.pop_front());
    if (give) begin
      r = mem_q.pop_front();
      if (!redir && (r.ep == epoch)) begin
        e = '{pc: r.addr, instr: data_of(r.addr), fault: err_of(r.addr)};
        mq.push_back(e);
        if (e.fault) m_halted = 1'b1;
      end
    end
    if (redir) begin
      epoch++;
      mq.delete();
      m_fetch_pc = {rpc[31:2], 2'b00};
      m_halted   = 1'b0;
      m_hold     = 1'b0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0);
  endtask

  vec_t        vt[5];
  logic [31:0] wrap_exp[3];
  logic [31:0] w_addrs[$];
  logic [31:0] w_pcs[$];
  logic [31:0] exp_pf_empty, exp_pf_flush;

  initial begin
    vt[0] = '{rpc: 32'h0000_2003, exp_addr: 32'h0000_2000};
    vt[1] = '{rpc: 32'h0000_0400, exp_addr: 32'h0000_0400};
    vt[2] = '{rpc: 32'hFFFF_FFFE, exp_addr: 32'hFFFF_FFFC};
    vt[3] = '{rpc: 32'h0000_0001, exp_addr: 32'h0000_0000};
    vt[4] = '{rpc: 32'h0000_1235, exp_addr: 32'h0000_1234};
    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;

    reset  = 1'b1;
    reset2 = 1'b1;
    idle_inputs();
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = '0;
    bus2.imem_req_ready = 1'b0;
    bus2.imem_rsp_valid = 1'b0;
    bus2.imem_rsp_data  = '0;
    bus2.imem_rsp_err   = 1'b0;
    bus2.dec_ready      = 1'b0;

    // sequential streaming
    do_reset();
    k_rdy = 1; k_rsp = 1; k_dec = 1;
    clr_obs();
    run(12);
    check("t1_first_fire", obs_first_fire, 32'h100);
    check("t1_first_pop", obs_first_pop, 32'h100);
    check("t1_n_fire", obs_n_fire, 12);

    // backpressure: credit limits requests to DEPTH
    do_reset();
    k_rdy = 1; k_rsp = 1; k_dec = 0;
    clr_obs();
    run(12);
    check("t2_n_fire", obs_n_fire, 4);
    check("t2_req_valid_off", bus.imem_req_valid, 0);
    k_dec = 1;
    clr_obs();
    run(8);
    check("t2_fire_per_pop", obs_n_fire, obs_n_pop - 1);

    // redirect with three requests in flight
    do_reset();
    k_rdy = 1; k_rsp = 0; k_dec = 0;
    run(3);
    step(1'b1, 32'h0000_2003);
    k_rsp = 1; k_dec = 1;
    clr_obs();
    run(10);
    check("t3_first_fire", obs_first_fire, 32'h2000);
    check("t3_first_pop", obs_first_pop, 32'h2000);

    // fetch fault halts issue until redirect
    do_reset();
    err_pc = 32'h0000_010C;
    k_rdy = 1; k_rsp = 1; k_dec = 1;
    clr_obs();
    run(20);
    check("t4_fault_seen", obs_fault_seen, 1);
    check("t4_fault_pc", obs_fault_pc, 32'h10C);
    check("t4_n_fire", obs_n_fire, 5);
    check("t4_halted", bus.imem_req_valid, 0);
    err_pc = 32'h1;

    // redirect vector table (alignment of redirect_pc)
    for (int i = 0; i < 5; i++) begin
      step(1'b1, vt[i].rpc);
      clr_obs();
      run(8);
      check("tab_first_fire", obs_first_fire, vt[i].exp_addr);
      check("tab_first_pop", obs_first_pop, vt[i].exp_addr);
    end

    // address wrap on a second instance reset to near the top of memory
    @(negedge clk);
    reset2 = 1'b1;
    bus2.imem_req_ready = 1'b1;
    bus2.dec_ready      = 1'b1;
    @(negedge clk);
    begin
      bit          prev_fire = 0;
      logic [31:0] prev_addr = '0;
      for (int i = 0; i < 10; i++) begin
        if (i > 0) @(negedge clk);
        reset2              = 1'b0;
        bus2.imem_rsp_valid = prev_fire;
        bus2.imem_rsp_data  = data_of(prev_addr);
        bus2.imem_rsp_err   = 1'b0;
        #1;
        if (bus2.dec_valid) w_pcs.push_back(bus2.dec_pc);
        prev_fire = bus2.imem_req_valid;
        prev_addr = bus2.imem_req_addr;
        if (prev_fire) w_addrs.push_back(bus2.imem_req_addr);
      end
    end
    for (int i = 0; i < 3; i++) begin
      check("t5_req_addr", (i < w_addrs.size()) ? w_addrs[i] : 32'hDEAD_BEEF, wrap_exp[i]);
      check("t5_dec_pc", (i < w_pcs.size()) ? w_pcs[i] : 32'hDEAD_BEEF, wrap_exp[i]);
    end

    // performance counters
    do_reset();
    k_rdy = 0; k_rsp = 0; k_dec = 0;
    step(1'b1, 32'h800);
    step(1'b1, 32'h900);
    k_dec = 1;
    run(5);
    k_dec = 0;
    run(1);
`ifdef FETCH_PERF_EN
    exp_pf_empty = 32'd5;
    exp_pf_flush = 32'd2;
`else
    exp_pf_empty = 32'd0;
    exp_pf_flush = 32'd0;
`endif
    check("t6_perf_empty", bus.perf_empty_cyc, exp_pf_empty);
    check("t6_perf_flush", {16'h0, bus.perf_flushes}, exp_pf_flush);

    // randomized traffic with redirects, faults and a mid-run reset
    do_reset();
    rand_err = 1;
    k_rdy = 2; k_rsp = 2; k_dec = 2;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      if ($urandom_range(0, 31) == 0) step(1'b1, $urandom);
      else step(1'b0, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
